// File: rtl/mux_rr_scheduler.sv
// mux_rr_scheduler: round-robin owner selection for a select-driven N_REQ:1 mux.
// Ownership moves through IDLE -> GRANT -> RELEASE. RELEASE is one dead cycle
// that lets the mux settle before the next owner is chosen. A hold counter
// force-releases an owner that keeps the mux for MAX_HOLD cycles.
module mux_rr_scheduler #(
  parameter int N_REQ    = 64,
  parameter int SEL_W    = 6,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [SEL_W-1:0] sel,
  output logic [N_REQ-1:0] grant,
  output logic             busy,
  output logic             timeout
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  localparam logic [7:0]       MAX_HOLD_C = 8'(MAX_HOLD);
  localparam logic [N_REQ-1:0] ONE_C      = {{(N_REQ-1){1'b0}}, 1'b1};

  // Round-robin search starting just after p and wrapping modulo N_REQ.
  // The last index visited is p itself, so a lone previous owner still wins.
  // The return value is {found, winner}.
  function automatic logic [SEL_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                             input logic [SEL_W-1:0] p);
    logic             found;
    logic [SEL_W-1:0] win;
    logic [SEL_W-1:0] idx;
    logic             hit;
    found = 1'b0;
    win   = {SEL_W{1'b0}};
    for (int k = 1; k <= N_REQ; k++) begin
      idx   = p + SEL_W'(k);
      hit   = r[idx];
      win   = (!found && hit) ? idx : win;
      found = found | hit;
    end
    return {found, win};
  endfunction

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;
  logic [7:0]       hold_q, hold_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic [SEL_W:0]   pick_s;
  logic             found_s;
  logic [SEL_W-1:0] winner_s;
  logic             owner_req_s;
  logic             hold_hit_s;
  logic             exit_s;

  assign pick_s      = rr_pick(req, ptr_q);
  assign found_s     = pick_s[SEL_W];
  assign winner_s    = pick_s[SEL_W-1:0];
  assign owner_req_s = req[sel_q];
  assign hold_hit_s  = (hold_q == MAX_HOLD_C);
  assign exit_s      = done | ~owner_req_s | hold_hit_s;

  // Next-state and next-output computation for the arbitration FSM.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    grant_d   = {N_REQ{1'b0}};
    busy_d    = 1'b0;
    timeout_d = 1'b0;
    hold_d    = hold_q;
    ptr_d     = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (found_s) begin
          state_d = ST_GRANT;
          sel_d   = winner_s;
          grant_d = ONE_C << winner_s;
          busy_d  = 1'b1;
          ptr_d   = winner_s;
          hold_d  = 8'd1;
        end else begin
          state_d = ST_IDLE;
          hold_d  = 8'd0;
        end
      end
      ST_GRANT: begin
        if (exit_s) begin
          // Timeout only when the hold limit is the sole reason for leaving.
          state_d   = ST_RELEASE;
          hold_d    = 8'd0;
          timeout_d = hold_hit_s & ~done & owner_req_s;
        end else begin
          state_d = ST_GRANT;
          grant_d = grant_q;
          busy_d  = 1'b1;
          hold_d  = hold_q + 8'd1;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
        hold_d  = 8'd0;
      end
      default: begin
        state_d = ST_IDLE;
        hold_d  = 8'd0;
      end
    endcase
  end

  // State and registered outputs; reset points ptr at N_REQ-1 so index 0 is searched first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sel_q     <= {SEL_W{1'b0}};
      grant_q   <= {N_REQ{1'b0}};
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      hold_q    <= 8'd0;
      ptr_q     <= {SEL_W{1'b1}};
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      hold_q    <= hold_d;
      ptr_q     <= ptr_d;
    end
  end

  assign sel     = sel_q;
  assign grant   = grant_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: doc/mux_rr_scheduler.md
MUX_RR_SCHEDULER -- requirements
Module: mux_rr_scheduler

Interface
REQ-001 Parameter N_REQ, default 64: number of requesters sharing the 64:1 select-driven mux; SHALL be a power of two.
REQ-002 Parameter SEL_W, default 6: select width; SHALL equal log2(N_REQ).
REQ-003 Parameter MAX_HOLD, default 16: maximum GRANT cycles before forced release; SHALL be 1..255.
REQ-004 Port clk  input  1  the single clock; all state on rising edge.
REQ-005 Port rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port req  input  N_REQ  per-requester request level; bit i requests mux input i.
REQ-007 Port done  input  1  the granted requester releases the mux; sampled only in GRANT.
REQ-008 Port sel  output  SEL_W  mux select, registered; index of the current/last owner.
REQ-009 Port grant  output  N_REQ  one-hot owner, registered; all-zero when not in GRANT.
REQ-010 Port busy  output  1  high exactly while in GRANT.
REQ-011 Port timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

Function
REQ-012 The FSM SHALL have three states: IDLE, GRANT, RELEASE.
REQ-013 IDLE: if any req bit is high, the block SHALL pick the winner and enter GRANT at the next edge; otherwise it SHALL remain in IDLE.
REQ-014 Winner selection SHALL be round-robin: search indices ptr+1, ptr+2, ... modulo N_REQ; the first index with req high wins.
REQ-015 The search SHALL wrap from N_REQ-1 to 0.
REQ-016 If the only requester is the previous owner, it SHALL be granted again.
REQ-017 On entering GRANT: sel = winner, grant = one-hot(winner), busy = 1, ptr = winner; latency from req seen in IDLE to grant is 1 cycle.
REQ-018 sel SHALL remain stable for the entire GRANT and RELEASE states, and SHALL hold its value in IDLE.
REQ-019 In GRANT, a hold counter SHALL count cycles spent in GRANT, from 1 on the first GRANT cycle.
REQ-020 GRANT SHALL exit to RELEASE at the next edge when any of the following holds: done = 1; req[sel] = 0; hold counter = MAX_HOLD.
REQ-021 If the exit is due only to the hold counter reaching MAX_HOLD, timeout SHALL pulse high for the first RELEASE cycle.
REQ-022 If done or req[sel] drop coincides with the hold counter reaching MAX_HOLD, the release SHALL be normal and timeout SHALL stay 0.
REQ-023 RELEASE SHALL last exactly one cycle, with grant = 0 and busy = 0, as a dead cycle for mux settling.
REQ-024 RELEASE SHALL then go to IDLE.
REQ-025 The minimum gap between consecutive grants SHALL be 2 cycles of no grant: RELEASE, then IDLE.
REQ-026 done SHALL be ignored outside GRANT.
REQ-027 req changes other than req[sel] SHALL NOT affect an ongoing GRANT.
REQ-028 At most one grant bit SHALL be high at any time.
REQ-029 grant SHALL equal one-hot(sel) whenever busy = 1.

Reset
REQ-030 rst_n low SHALL immediately, asynchronously, force: state = IDLE, sel = 0, grant = 0, busy = 0, timeout = 0, hold counter = 0, ptr = N_REQ-1, so the first search begins at index 0.
REQ-031 Reset asserted mid-GRANT SHALL drop grant and busy without passing through RELEASE and without a timeout pulse.
REQ-032 After rst_n rises, the first arbitration SHALL occur at the first rising edge with rst_n high.

Verification
REQ-033 Single request: after reset, req = 1<<5 held, done pulsed on the 3rd GRANT cycle -> grant = 1<<5 and sel = 5 one cycle after req; busy for 3 cycles; RELEASE; IDLE.
REQ-034 Round-robin wrap: req bits 0, 40 and 63 all held high, each owner pulses done after 1 cycle -> grant order 0, 40, 63, 0, with 2 idle cycles between grants.
REQ-035 Timeout: req = 1<<7 held, done never asserted, MAX_HOLD = 16 -> busy for exactly 16 cycles; timeout pulses once in RELEASE; then 7 is re-granted.
REQ-036 Coincident events: done asserted on hold cycle 16 -> release with timeout = 0.
REQ-037 Request drop: req[sel] cleared mid-grant -> release at the next edge with timeout = 0.
REQ-038 Reset mid-grant: rst_n pulled low during GRANT of index 9 -> grant = 0 and sel = 0 immediately; after release with req bits 3 and 9 high, index 3 is granted first.
